// File: rtl/matmul_lane_engine.sv
// Tiled integer matmul sequencer: LANES output columns per tile from
// A/B SRAM reads, rounded and saturated results written to the C SRAM.
module matmul_lane_engine #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int LANES  = 4,
  parameter int MAX_M  = 784,
  parameter int MAX_K  = 288,
  parameter int MAX_N  = 64,
  localparam int G_MAX = (MAX_N + LANES - 1) / LANES,
  localparam int AA_W  = $clog2(MAX_M * MAX_K),
  localparam int BA_W  = $clog2(MAX_K * G_MAX),
  localparam int CA_W  = $clog2(MAX_M * G_MAX),
  localparam int MW    = $clog2(MAX_M) + 1,
  localparam int KW    = $clog2(MAX_K) + 1,
  localparam int NW    = $clog2(MAX_N) + 1,
  localparam int GW    = $clog2(G_MAX) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [MW-1:0]           M_in,
  input  logic [KW-1:0]           K_in,
  input  logic [NW-1:0]           N_in,
  input  logic [5:0]              shift,
  output logic                    a_rd_en,
  output logic [AA_W-1:0]         a_addr,
  input  logic [DATA_W-1:0]       a_rdata,
  output logic                    b_rd_en,
  output logic [BA_W-1:0]         b_addr,
  input  logic [LANES*DATA_W-1:0] b_rdata,
  output logic                    c_wr_en,
  output logic [CA_W-1:0]         c_addr,
  output logic [LANES*DATA_W-1:0] c_wdata,
  output logic [LANES-1:0]        c_wmask,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  output logic                    aborted
);

  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH, WRITE} state_t;

  localparam logic signed [ACC_W:0] SAT_HI =
    (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SAT_LO = ~SAT_HI;

  state_t state, state_n;

  logic [MW-1:0]   m_r, i_cnt;
  logic [KW-1:0]   k_r, k_cnt;
  logic [NW-1:0]   n_r;
  logic [GW-1:0]   g_r, g_cnt, g_in;
  logic [5:0]      shift_r;
  logic [AA_W-1:0] a_row;
  logic            rd_en, v_d, first_d;
  logic            dims_bad, accept, reject, kill;
  logic            last_k, last_g, last_i, last_tile;

  logic signed [ACC_W-1:0]    acc  [LANES];
  logic signed [2*DATA_W-1:0] prod [LANES];

  function automatic logic [DATA_W-1:0] requant(
    input logic signed [ACC_W-1:0] a,
    input logic [5:0]              s
  );
    logic signed [ACC_W:0] t;
    logic signed [ACC_W:0] rnd;
    rnd = '0;
    if (s != 6'd0)
      rnd = signed'((ACC_W+1)'(1) << (s - 6'd1));
    t = {a[ACC_W-1], a};
    t = t + rnd;
    t = t >>> s;
    if (t > SAT_HI)
      requant = {1'b0, {(DATA_W-1){1'b1}}};
    else if (t < SAT_LO)
      requant = {1'b1, {(DATA_W-1){1'b0}}};
    else
      requant = t[DATA_W-1:0];
  endfunction

  assign g_in = GW'((N_in + NW'(LANES - 1)) / NW'(LANES));

  assign dims_bad = (M_in == '0) || (M_in > MW'(MAX_M))
                 || (K_in == '0) || (K_in > KW'(MAX_K))
                 || (N_in == '0) || (N_in > NW'(MAX_N));

  assign last_k    = (k_cnt == k_r - KW'(1));
  assign last_g    = (g_cnt == g_r - GW'(1));
  assign last_i    = (i_cnt == m_r - MW'(1));
  assign last_tile = last_i && last_g;

  assign busy    = (state != IDLE);
  assign a_rd_en = rd_en;
  assign b_rd_en = rd_en;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    reject  = 1'b0;
    kill    = 1'b0;
    unique case (state)
      IDLE:
        if (start) begin
          if (dims_bad) begin
            reject = 1'b1;
          end else begin
            accept  = 1'b1;
            state_n = ISSUE;
          end
        end
      ISSUE: if (last_k) state_n = FLUSH;
      FLUSH: state_n = WRITE;
      WRITE: state_n = last_tile ? IDLE : ISSUE;
      default: state_n = IDLE;
    endcase
    if (state != IDLE && abort) begin
      kill    = 1'b1;
      state_n = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_en   <= 1'b0;
      c_wr_en <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      aborted <= 1'b0;
      m_r     <= '0;
      k_r     <= '0;
      n_r     <= '0;
      g_r     <= '0;
      shift_r <= '0;
      i_cnt   <= '0;
      g_cnt   <= '0;
      k_cnt   <= '0;
      a_row   <= '0;
      a_addr  <= '0;
      b_addr  <= '0;
      c_addr  <= '0;
    end else begin
      rd_en   <= (state_n == ISSUE);
      c_wr_en <= (state_n == WRITE);
      done    <= reject || (state == WRITE && last_tile && !kill);
      err     <= reject;
      aborted <= kill;
      if (accept) begin
        m_r     <= M_in;
        k_r     <= K_in;
        n_r     <= N_in;
        g_r     <= g_in;
        shift_r <= shift;
        i_cnt   <= '0;
        g_cnt   <= '0;
        k_cnt   <= '0;
        a_row   <= '0;
        a_addr  <= '0;
        b_addr  <= '0;
        c_addr  <= '0;
      end else if (state == ISSUE && !last_k) begin
        k_cnt  <= k_cnt + KW'(1);
        a_addr <= a_addr + AA_W'(1);
        b_addr <= b_addr + BA_W'(g_r);
      end else if (state == WRITE && !last_tile) begin
        // addresses rewind to the next tile's first operands
        k_cnt  <= '0;
        c_addr <= c_addr + CA_W'(1);
        if (last_g) begin
          g_cnt  <= '0;
          i_cnt  <= i_cnt + MW'(1);
          a_row  <= a_row + AA_W'(k_r);
          a_addr <= a_row + AA_W'(k_r);
          b_addr <= '0;
        end else begin
          g_cnt  <= g_cnt + GW'(1);
          a_addr <= a_row;
          b_addr <= BA_W'(g_cnt) + BA_W'(1);
        end
      end
    end
  end

  always_comb begin
    for (int l = 0; l < LANES; l++)
      prod[l] = signed'(a_rdata)
              * signed'(b_rdata[l*DATA_W +: DATA_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_d     <= 1'b0;
      first_d <= 1'b0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      v_d     <= rd_en;
      first_d <= rd_en && (k_cnt == '0);
      if (v_d)
        for (int l = 0; l < LANES; l++)
          acc[l] <= first_d ? ACC_W'(prod[l])
                            : acc[l] + ACC_W'(prod[l]);
    end
  end

  always_comb begin
    c_wdata = '0;
    c_wmask = '0;
    if (c_wr_en)
      for (int l = 0; l < LANES; l++)
        if (int'(g_cnt) * LANES + l < int'(n_r)) begin
          c_wmask[l] = 1'b1;
          c_wdata[l*DATA_W +: DATA_W] = requant(acc[l], shift_r);
        end
  end

endmodule
